// File: rtl/chan_accum_act_pkg.sv
// Shared definitions for chan_accum_act: accumulator width, FSM state codes
// and saturation bounds for a signed DW-bit lane.
package acc_pkg;

    // Accumulator width: the lane width plus enough headroom for CH_IN channel sums
    function automatic int acc_w_calc(input int dw, input int ch_in);
        return dw + $clog2(ch_in);
    endfunction

    // Largest positive value of a signed dw-bit lane (dw <= 64)
    function automatic logic [63:0] sat_max_f(input int dw);
        return (64'd1 << (dw - 1)) - 64'd1;
    endfunction

    // Most negative value of a signed dw-bit lane, low dw bits meaningful
    function automatic logic [63:0] sat_min_f(input int dw);
        return 64'd1 << (dw - 1);
    endfunction

    // Column FSM: S_IDLE means the accumulators hold no partial column
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_ACC  = 1'b1;

endpackage

// File: rtl/chan_accum_act_acc_lane.sv
// acc_lane: one lane of the channel accumulator. Holds the running partial
// sum, forms acc + psum + bias on the last beat, saturates to signed DW and
// optionally applies ReLU (macro ACC_RELU_EN). The result is combinational;
// the output register lives in the top.
module acc_lane
    import acc_pkg::*;
#(
    parameter int DW    = 32,
    parameter int CH_IN = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          beat_i,
    input  logic          first_i,
    input  logic          last_i,
    input  logic [DW-1:0] psum_i,
    input  logic [DW-1:0] bias_i,
    output logic [DW-1:0] res_o
);
    localparam int ACC_W = acc_w_calc(DW, CH_IN);
    // one extra bit so adding the bias to a full accumulator cannot wrap
    localparam int SUM_W = ACC_W + 1;
    localparam logic [DW-1:0] SAT_MAX = DW'(sat_max_f(DW));
    localparam logic [DW-1:0] SAT_MIN = DW'(sat_min_f(DW));
    localparam logic signed [SUM_W-1:0] MAX_EXT = {{(SUM_W-DW){SAT_MAX[DW-1]}}, SAT_MAX};
    localparam logic signed [SUM_W-1:0] MIN_EXT = {{(SUM_W-DW){SAT_MIN[DW-1]}}, SAT_MIN};

    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] base_s;
    logic signed [ACC_W-1:0] psum_ext_s;
    logic signed [SUM_W-1:0] sum_s;
    logic        [DW-1:0]    sat_s;

    // Running sum, final sum with bias, saturation and activation
    always_comb begin
        base_s     = first_i ? '0 : acc_q;
        psum_ext_s = {{(ACC_W-DW){psum_i[DW-1]}}, psum_i};
        sum_s      = {base_s[ACC_W-1], base_s}
                   + {psum_ext_s[ACC_W-1], psum_ext_s}
                   + {{(SUM_W-DW){bias_i[DW-1]}}, bias_i};
        acc_d = acc_q;
        if (beat_i) begin
            if (last_i) begin
                acc_d = '0;
            end else begin
                acc_d = base_s + psum_ext_s;
            end
        end else begin
            acc_d = acc_q;
        end
        if (sum_s > MAX_EXT) begin
            sat_s = SAT_MAX;
        end else if (sum_s < MIN_EXT) begin
            sat_s = SAT_MIN;
        end else begin
            sat_s = sum_s[DW-1:0];
        end
`ifdef ACC_RELU_EN
        res_o = sat_s[DW-1] ? '0 : sat_s;
`else
        res_o = sat_s;
`endif
    end

    // Accumulator register; flush clears it like reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else if (clr_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/chan_accum_act.sv
// chan_accum_act: sums CH_IN per-channel partial-sum columns of HIT lanes,
// adds the output-channel bias, saturates, optionally applies ReLU
// (macro ACC_RELU_EN) and presents the column on a valid/ready output.
// The output register is separate from the accumulators so the next column
// can accumulate while a finished one waits for the consumer.
module chan_accum_act
    import acc_pkg::*;
#(
    parameter int HIT   = 56,
    parameter int DW    = 32,
    parameter int FW    = 8,
    parameter int CH_IN = 64,
    parameter int COLS  = 56
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic [HIT*DW-1:0] psum_i,
    input  logic              psum_valid_i,
    output logic              psum_ready_o,
    input  logic [DW-1:0]     bias_i,
    output logic [HIT*DW-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              out_last_o
);
    // FW only documents the fixed-point format; arithmetic is format-agnostic
    localparam int CW  = (CH_IN > 1) ? $clog2(CH_IN) : 1;
    localparam int CLW = (COLS > 1) ? $clog2(COLS) : 1;

    logic [0:0]        state_q, state_d;
    logic [CW-1:0]     ch_cnt_q, ch_cnt_d;
    logic [CLW-1:0]    col_cnt_q, col_cnt_d;
    logic [DW-1:0]     bias_q, bias_d, bias_sel_s;
    logic [HIT*DW-1:0] data_q, data_d, res_s;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic              first_s, ch_last_s, beat_s, load_s, xfer_s;

    // Handshake decode; stall only when the last beat would overwrite an unaccepted result
    always_comb begin
        first_s      = (state_q == S_IDLE);
        ch_last_s    = (ch_cnt_q == CW'(CH_IN - 1));
        psum_ready_o = !(ch_last_s && valid_q && !ready_i);
        beat_s       = psum_valid_i && psum_ready_o;
        load_s       = beat_s && ch_last_s;
        xfer_s       = valid_q && ready_i;
        bias_sel_s   = first_s ? bias_i : bias_q;
    end

    genvar g;
    generate
        for (g = 0; g < HIT; g++) begin : g_lane
            acc_lane #(
                .DW    (DW),
                .CH_IN (CH_IN)
            ) u_lane (
                .clk     (clk),
                .rst     (rst),
                .clr_i   (flush_i),
                .beat_i  (beat_s),
                .first_i (first_s),
                .last_i  (ch_last_s),
                .psum_i  (psum_i[g*DW +: DW]),
                .bias_i  (bias_sel_s),
                .res_o   (res_s[g*DW +: DW])
            );
        end
    endgenerate

    // Column FSM, channel counter and bias capture on the first beat
    always_comb begin
        state_d  = state_q;
        ch_cnt_d = ch_cnt_q;
        bias_d   = bias_q;
        case (state_q)
            S_IDLE: begin
                if (beat_s) begin
                    bias_d = bias_i;
                    if (ch_last_s) begin
                        state_d  = S_IDLE;
                        ch_cnt_d = '0;
                    end else begin
                        state_d  = S_ACC;
                        ch_cnt_d = CW'(1);
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACC: begin
                if (beat_s) begin
                    if (ch_last_s) begin
                        state_d  = S_IDLE;
                        ch_cnt_d = '0;
                    end else begin
                        ch_cnt_d = ch_cnt_q + CW'(1);
                    end
                end else begin
                    state_d = S_ACC;
                end
            end
            default: begin
                state_d  = S_IDLE;
                ch_cnt_d = '0;
            end
        endcase
    end

    // Output register, valid and column counter; a load wins over a transfer
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        last_d    = last_q;
        col_cnt_d = col_cnt_q;
        if (load_s) begin
            data_d    = res_s;
            valid_d   = 1'b1;
            last_d    = (col_cnt_q == CLW'(COLS - 1));
            col_cnt_d = (col_cnt_q == CLW'(COLS - 1)) ? '0 : col_cnt_q + CLW'(1);
        end else if (xfer_s) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // State registers; flush returns everything to reset values
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ch_cnt_q  <= '0;
            col_cnt_q <= '0;
            bias_q    <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
        end else if (flush_i) begin
            state_q   <= S_IDLE;
            ch_cnt_q  <= '0;
            col_cnt_q <= '0;
            bias_q    <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ch_cnt_q  <= ch_cnt_d;
            col_cnt_q <= col_cnt_d;
            bias_q    <= bias_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
        end
    end

    assign data_o     = data_q;
    assign valid_o    = valid_q;
    assign out_last_o = last_q;

endmodule

// File: tb/tb_chan_accum_act.sv
// Self-checking bench for chan_accum_act: random and directed columns
// compared against a plain-arithmetic reference model of the column sums.
module tb_chan_accum_act;
    localparam int HIT   = 56;
    localparam int DW    = 32;
    localparam int CH_IN = 64;
    localparam int COLS  = 56;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush_i;
    logic [HIT*DW-1:0] psum_i;
    logic              psum_valid_i;
    logic              psum_ready_o;
    logic [DW-1:0]     bias_i;
    logic [HIT*DW-1:0] data_o;
    logic              valid_o;
    logic              ready_i;
    logic              out_last_o;

    chan_accum_act #(.HIT(HIT), .DW(DW), .FW(8), .CH_IN(CH_IN), .COLS(COLS)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush_i),
        .psum_i       (psum_i),
        .psum_valid_i (psum_valid_i),
        .psum_ready_o (psum_ready_o),
        .bias_i       (bias_i),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .out_last_o   (out_last_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model: beats seen in the current column, per-lane sums, outputs
    longint            sum_m [HIT];
    longint            bias_m;
    int                nb_m;
    int                col_m;
    logic              exp_valid;
    logic              exp_last;
    logic [HIT*DW-1:0] exp_data;
    logic [DW-1:0]     ps [HIT];
    logic [DW-1:0]     const_val;

    function automatic logic [DW-1:0] act(input longint v);
        longint r;
        r = v;
        if (r > 64'sd2147483647) r = 64'sd2147483647;
        if (r < -64'sd2147483648) r = -64'sd2147483648;
`ifdef ACC_RELU_EN
        if (r < 0) r = 0;
`endif
        return r[DW-1:0];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < HIT; k++) sum_m[k] = 0;
        bias_m = 0; nb_m = 0; col_m = 0;
        exp_valid = 1'b0; exp_last = 1'b0; exp_data = '0;
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_data(input string tag, input logic [HIT*DW-1:0] obs, input logic [HIT*DW-1:0] exp);
        int bad;
        checks++;
        assert (obs === exp) else begin
            errors++;
            bad = 0;
            for (int k = HIT - 1; k >= 0; k--) if (obs[k*DW +: DW] !== exp[k*DW +: DW]) bad = k;
            $error("FAIL %s lane %0d observed=%h expected=%h", tag, bad, obs[bad*DW +: DW], exp[bad*DW +: DW]);
        end
    endtask

    task automatic chk_lane0(input string tag, input logic [DW-1:0] exp);
        logic [DW-1:0] obs;
        obs = data_o[DW-1:0];
        checks++;
        assert (valid_o === 1'b1 && obs === exp) else begin
            errors++;
            $error("FAIL %s observed valid=%b lane0=%h expected valid=1 lane0=%h", tag, valid_o, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] gen(input int mode);
        case (mode)
            0: return DW'($urandom);
            1: return const_val;
            default: return DW'(int'($urandom_range(0, 4000)) - 2000);
        endcase
    endfunction

    // one clock: drive inputs, check ready, advance, update model, check outputs
    task automatic step(input logic pv, input logic rdy, input logic fl, input int mode);
        logic exp_ready, beat, xfer, load;
        for (int k = 0; k < HIT; k++) begin
            ps[k] = gen(mode);
            psum_i[k*DW +: DW] = ps[k];
        end
        psum_valid_i = pv; ready_i = rdy; flush_i = fl;
        #2;
        exp_ready = !((nb_m == CH_IN - 1) && exp_valid && !rdy);
        chk_bit("psum_ready", psum_ready_o, exp_ready);
        @(posedge clk); #1;
        if (fl) begin
            model_reset();
        end else begin
            beat = pv && exp_ready;
            xfer = exp_valid && rdy;
            load = 1'b0;
            if (beat) begin
                if (nb_m == 0) begin
                    bias_m = longint'($signed(bias_i));
                    for (int k = 0; k < HIT; k++) sum_m[k] = 0;
                end
                for (int k = 0; k < HIT; k++) sum_m[k] += longint'($signed(ps[k]));
                if (nb_m == CH_IN - 1) begin
                    load = 1'b1;
                    nb_m = 0;
                end else begin
                    nb_m++;
                end
            end
            if (load) begin
                for (int k = 0; k < HIT; k++) exp_data[k*DW +: DW] = act(sum_m[k] + bias_m);
                exp_valid = 1'b1;
                exp_last = (col_m == COLS - 1);
                col_m = (col_m + 1) % COLS;
            end else if (xfer) begin
                exp_valid = 1'b0;
            end
        end
        chk_bit("valid_o", valid_o, exp_valid);
        chk_bit("out_last_o", out_last_o, exp_last);
        chk_data("data_o", data_o, exp_data);
    endtask

    task automatic beats(input int n, input logic rdy, input int mode);
        for (int i = 0; i < n; i++) step(1'b1, rdy, 1'b0, mode);
    endtask

    initial begin
        rst = 1'b1; flush_i = 1'b0; psum_valid_i = 1'b0; ready_i = 1'b0;
        psum_i = '0; bias_i = '0; const_val = '0;
        model_reset();
        @(posedge clk); #1;
        chk_bit("rst_valid", valid_o, 1'b0);
        chk_bit("rst_last", out_last_o, 1'b0);
        chk_bit("rst_ready", psum_ready_o, 1'b1);
        chk_data("rst_data", data_o, '0);
        rst = 1'b0;

        // 1.0 per beat over 64 channels plus 0.5 bias
        const_val = 32'h0000_0100; bias_i = 32'h0000_0080;
        beats(CH_IN, 1'b1, 1);
        chk_lane0("sum_4080", 32'h0000_4080);
        step(1'b0, 1'b1, 1'b0, 1);

        // positive and negative saturation
        const_val = 32'h7FFF_FFFF; bias_i = 32'h0000_0000;
        beats(CH_IN, 1'b1, 1);
        chk_lane0("sat_max", 32'h7FFF_FFFF);
        const_val = 32'h8000_0000;
        beats(CH_IN, 1'b1, 1);
`ifdef ACC_RELU_EN
        chk_lane0("sat_min", 32'h0000_0000);
`else
        chk_lane0("sat_min", 32'h8000_0000);
`endif
        step(1'b0, 1'b1, 1'b0, 2);

        // backpressure: hold column, next column stalls only on its last beat
        bias_i = DW'($urandom_range(0, 1000));
        beats(CH_IN, 1'b0, 2);
        bias_i = DW'($urandom);
        beats(CH_IN, 1'b0, 2);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 2);
        step(1'b1, 1'b1, 1'b0, 2);
        step(1'b0, 1'b0, 1'b0, 2);
        step(1'b0, 1'b1, 1'b0, 2);

        // flush alone, then 57 back-to-back columns to cross the COLS wrap
        step(1'b0, 1'b1, 1'b1, 2);
        for (int c = 0; c < COLS + 1; c++) begin
            bias_i = DW'($urandom_range(0, 2000)) - DW'(1000);
            beats(CH_IN, 1'b1, (c % 3 == 0) ? 0 : 2);
        end

        // flush mid-column (with and without a simultaneous beat), bias resampled
        bias_i = 32'h0000_1234;
        beats(29, 1'b1, 2);
        step(1'b1, 1'b1, 1'b1, 2);
        bias_i = 32'h0000_0042;
        beats(CH_IN, 1'b0, 2);
        beats(10, 1'b1, 2);
        step(1'b0, 1'b1, 1'b1, 2);
        beats(CH_IN, 1'b1, 2);

        // random valid/ready traffic
        for (int i = 0; i < 6 * CH_IN; i++) begin
            if (nb_m == 0) bias_i = DW'($urandom);
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 2);
        end

        // async reset mid-column
        step(1'b0, 1'b1, 1'b0, 2);
        beats(20, 1'b1, 2);
        #2 rst = 1'b1;
        #1;
        chk_bit("arst_mid_valid", valid_o, 1'b0);
        chk_data("arst_mid_data", data_o, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();

        // async reset while a result is held
        bias_i = 32'h0000_0777;
        beats(CH_IN, 1'b0, 2);
        beats(5, 1'b0, 2);
        #2 rst = 1'b1;
        #1;
        chk_bit("arst_hold_valid", valid_o, 1'b0);
        chk_bit("arst_hold_last", out_last_o, 1'b0);
        chk_data("arst_hold_data", data_o, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        bias_i = 32'h0000_0010;
        beats(CH_IN, 1'b1, 2);
        step(1'b0, 1'b1, 1'b0, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
